// File: rtl/uart_tx_fifo.sv
// ----------------------------------------------------------------------------
// uart_tx_fifo : FIFO-buffered UART transmitter with configurable framing
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module uart_tx_fifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int CLK_DIV    = 434,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                          clk,
  input  logic                          asyncreset,
  input  logic                          WE,
  input  logic [DATA_W-1:0]             WD,
  input  logic                          clr_overflow,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          busy,
  output logic                          overflow,
  output logic                          tx_serial
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(CLK_DIV);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_DIV - 1);
  localparam logic [3:0]    DATA_LAST = 4'(DATA_W - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic [CW-1:0] DEPTH     = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t             state_q, state_d;
  logic [BW-1:0]      baud_q, baud_d;
  logic [3:0]         bit_q, bit_d;
  logic [DATA_W-1:0]  shift_q, shift_d;
  logic               par_q, par_d;
  logic               tx_q, tx_d;
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic               ovf_q, ovf_d;
  logic [DATA_W-1:0]  mem_q [FIFO_DEPTH];

  logic               wr_en, pop;
  logic [DATA_W-1:0]  head;

  assign full      = (count_q == DEPTH);
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign busy      = (state_q != S_IDLE);
  assign overflow  = ovf_q;
  assign tx_serial = tx_q;
  assign head      = mem_q[rd_ptr_q];

  // Full is the registered value, so a write is dropped even if a pop frees space this cycle.
  always_comb begin
    wr_en    = WE && !full;
    wr_ptr_d = wr_ptr_q + AW'(wr_en);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q + CW'(wr_en) - CW'(pop);
    ovf_d    = (WE && full) || (ovf_q && !clr_overflow);
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        tx_d   = 1'b1;
        baud_d = '0;
        bit_d  = '0;
        if (!empty) begin
          pop     = 1'b1;
          shift_d = head;
          par_d   = (^head) ^ (PARITY == 2);
          state_d = S_START;
          tx_d    = 1'b0;
        end
      end
      S_START: begin
        baud_d = baud_q + 1'b1;
        if (baud_q == BAUD_LAST) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = S_DATA;
          tx_d    = shift_q[0];
        end
      end
      S_DATA: begin
        baud_d = baud_q + 1'b1;
        if (baud_q == BAUD_LAST) begin
          baud_d  = '0;
          shift_d = shift_q >> 1;
          if (bit_q == DATA_LAST) begin
            bit_d = '0;
            if (PARITY != 0) begin
              state_d = S_PARITY;
              tx_d    = par_q;
            end else begin
              state_d = S_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d = bit_q + 1'b1;
            tx_d  = shift_q[1];
          end
        end
      end
      S_PARITY: begin
        baud_d = baud_q + 1'b1;
        if (baud_q == BAUD_LAST) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = S_STOP;
          tx_d    = 1'b1;
        end
      end
      S_STOP: begin
        baud_d = baud_q + 1'b1;
        if (baud_q == BAUD_LAST) begin
          baud_d = '0;
          if (bit_q == STOP_LAST) begin
            bit_d = '0;
            // Chain straight into the next frame so busy never drops between entries.
            if (!empty) begin
              pop     = 1'b1;
              shift_d = head;
              par_d   = (^head) ^ (PARITY == 2);
              state_d = S_START;
              tx_d    = 1'b0;
            end else begin
              state_d = S_IDLE;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge asyncreset) begin
    if (!asyncreset) begin
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      tx_q     <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      tx_q     <= tx_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= WD;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
// ----------------------------------------------------------------------------
// tb_uart_tx_fifo : directed bench, three framing variants driven in lockstep
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       asyncreset;
  logic       we;
  logic       clr;
  logic [7:0] wd;
  logic [2:0] full_w, empty_w, busy_w, ovf_w, tx_w;
  logic [4:0] cnt_w [3];

  int n_tests = 0;
  int n_fail  = 0;
  int ncyc    = 0;
  int t_start = 0;
  logic [7:0] exp_q [$];

  always #5 clk = ~clk;

  uart_tx_fifo #(.DATA_W(8), .FIFO_DEPTH(16), .CLK_DIV(4), .PARITY(0), .STOP_BITS(1)) u_p0 (
    .clk(clk), .asyncreset(asyncreset), .WE(we), .WD(wd), .clr_overflow(clr),
    .full(full_w[0]), .empty(empty_w[0]), .count(cnt_w[0]), .busy(busy_w[0]),
    .overflow(ovf_w[0]), .tx_serial(tx_w[0]));

  uart_tx_fifo #(.DATA_W(8), .FIFO_DEPTH(16), .CLK_DIV(4), .PARITY(1), .STOP_BITS(1)) u_p1 (
    .clk(clk), .asyncreset(asyncreset), .WE(we), .WD(wd), .clr_overflow(clr),
    .full(full_w[1]), .empty(empty_w[1]), .count(cnt_w[1]), .busy(busy_w[1]),
    .overflow(ovf_w[1]), .tx_serial(tx_w[1]));

  uart_tx_fifo #(.DATA_W(8), .FIFO_DEPTH(16), .CLK_DIV(4), .PARITY(2), .STOP_BITS(2)) u_p2 (
    .clk(clk), .asyncreset(asyncreset), .WE(we), .WD(wd), .clr_overflow(clr),
    .full(full_w[2]), .empty(empty_w[2]), .count(cnt_w[2]), .busy(busy_w[2]),
    .overflow(ovf_w[2]), .tx_serial(tx_w[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Instance i uses parity mode i; only instance 2 has two stop bits.
  function automatic int frame_len(input int i);
    return (9 + ((i != 0) ? 1 : 0) + ((i == 2) ? 2 : 1)) * 4;
  endfunction

  // Expected line level t cycles after the first start-bit edge, frames back to back.
  function automatic logic exp_tx(input int i, input int t);
    int len;
    int f;
    int o;
    logic [7:0] d;
    len = frame_len(i);
    if (t < 0) return 1'b1;
    f = t / len;
    o = (t % len) / 4;
    if (f >= exp_q.size()) return 1'b1;
    d = exp_q[f];
    if (o == 0) return 1'b0;
    if (o <= 8) return d[o-1];
    if (i != 0 && o == 9) return (^d) ^ (i == 2);
    return 1'b1;
  endfunction

  function automatic logic exp_busy(input int i, input int t);
    return (t >= 0) && (t < exp_q.size() * frame_len(i));
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
    ncyc++;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("tx%0d_t%0d", i, ncyc - t_start), 32'(tx_w[i]), 32'(exp_tx(i, ncyc - t_start)));
      chk($sformatf("busy%0d_t%0d", i, ncyc - t_start), 32'(busy_w[i]), 32'(exp_busy(i, ncyc - t_start)));
    end
  endtask

  task automatic wr(input logic [7:0] b);
    we = 1'b1;
    wd = b;
    cyc();
    we = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s_tx%0d", tag, i), 32'(tx_w[i]), 32'd1);
      chk($sformatf("%s_busy%0d", tag, i), 32'(busy_w[i]), 32'd0);
      chk($sformatf("%s_empty%0d", tag, i), 32'(empty_w[i]), 32'd1);
      chk($sformatf("%s_full%0d", tag, i), 32'(full_w[i]), 32'd0);
      chk($sformatf("%s_count%0d", tag, i), 32'(cnt_w[i]), 32'd0);
      chk($sformatf("%s_ovf%0d", tag, i), 32'(ovf_w[i]), 32'd0);
    end
  endtask

  task automatic check_fifo(input string tag, input int c, input int f, input int o);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s_count%0d", tag, i), 32'(cnt_w[i]), 32'(c));
      chk($sformatf("%s_full%0d", tag, i), 32'(full_w[i]), 32'(f));
      chk($sformatf("%s_ovf%0d", tag, i), 32'(ovf_w[i]), 32'(o));
    end
  endtask

  initial begin
    asyncreset = 1'b1;
    we  = 1'b0;
    wd  = 8'h00;
    clr = 1'b0;
    #2 asyncreset = 1'b0;
    #1 check_idle("reset");
    cyc();
    cyc();
    asyncreset = 1'b1;
    cyc();

    // Single frames: 0x55 then 0x07 on all three framings.
    exp_q = '{8'h55};
    t_start = ncyc + 2;
    wr(8'h55);
    check_fifo("w55", 1, 0, 0);
    repeat (50) cyc();
    check_idle("f55_end");

    exp_q = '{8'h07};
    t_start = ncyc + 2;
    wr(8'h07);
    repeat (50) cyc();
    check_idle("f07_end");

    // Back-to-back frames with the second write landing on the pop edge.
    exp_q = '{8'hA5, 8'h3C};
    t_start = ncyc + 2;
    wr(8'hA5);
    wr(8'h3C);
    check_fifo("b2b", 1, 0, 0);
    repeat (100) cyc();
    check_idle("b2b_end");

    // Fill past capacity, then overflow set-vs-clear priority.
    exp_q.delete();
    for (int k = 0; k < 17; k++) exp_q.push_back(8'(k * 37 + 5));
    t_start = ncyc + 2;
    for (int k = 0; k < 17; k++) wr(exp_q[k]);
    wr(8'hEE);
    check_fifo("fill", 16, 1, 1);
    we  = 1'b1;
    wd  = 8'hDD;
    clr = 1'b1;
    cyc();
    we  = 1'b0;
    clr = 1'b0;
    check_fifo("clr_vs_drop", 16, 1, 1);
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    check_fifo("clr_alone", 16, 1, 0);
    repeat (17 * 48 + 4) cyc();
    check_idle("drain_end");

    // Asynchronous reset in the middle of data bit 3 with five entries queued.
    exp_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    t_start = ncyc + 2;
    for (int k = 0; k < 6; k++) wr(exp_q[k]);
    while (ncyc - t_start < 17) cyc();
    check_fifo("pre_rst", 5, 0, 0);
    #2 asyncreset = 1'b0;
    #1 check_idle("mid_rst");
    exp_q.delete();
    cyc();
    cyc();
    asyncreset = 1'b1;
    cyc();

    exp_q = '{8'h81};
    t_start = ncyc + 2;
    wr(8'h81);
    repeat (50) cyc();
    check_idle("f81_end");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Parametrised buffered UART transmitter that replaces the fixed single-byte serial path behind the core's tx_serial pin. The core's store path writes bytes into an internal FIFO. A framing FSM drains the FIFO and serialises each entry with configurable data width, parity, stop bits and bit period. It sits beside datamem, driven by the same store strobe/data wiring (WE/WD), and owns the top-level tx_serial output.

Parameters:
DATA_W, 8, data bits per frame (5..9)
FIFO_DEPTH, 16, FIFO entries; power of two, >=2
CLK_DIV, 434, clk cycles per serial bit; >=2
PARITY, 0, 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, number of stop bits (1 or 2)

Ports:
clk  input  1  system clock, rising edge
asyncreset  input  1  asynchronous, active-low reset
WE  input  1  write strobe, one entry per asserted cycle
WD  input  DATA_W  write data
clr_overflow  input  1  clears the overflow flag
full  output  1  FIFO holds FIFO_DEPTH entries
empty  output  1  FIFO holds 0 entries
count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
busy  output  1  FSM not in IDLE
overflow  output  1  sticky flag: a write was dropped
tx_serial  output  1  serial line, registered, idles high

Behaviour:
- Reset (asyncreset=0, takes effect immediately without a clock): tx_serial=1, busy=0, empty=1, full=0, count=0, overflow=0, pointers=0, baud and bit counters=0, state=IDLE. FIFO contents are discarded. Reset mid-frame returns the line high at once and truncates the frame.
- FIFO write: accepted on a clk edge when WE=1 and full=0 (full as registered before that edge). WE=1 with full=1 drops the data and sets overflow, even if a pop occurs in the same cycle.
- FIFO pop and write in the same cycle: count stays unchanged and both pointers advance.
- Pointers wrap modulo FIFO_DEPTH. full and empty are derived from count.
- overflow: set by a dropped write, cleared by clr_overflow=1. If both happen in the same cycle, set wins.
- FSM states: IDLE, START, DATA, PARITY, STOP. Each bit lasts exactly CLK_DIV cycles, timed by a baud counter running 0..CLK_DIV-1.
- IDLE: tx_serial=1. If empty=0, pop the FIFO head into the shift register and enter START on the same edge.
- START: tx_serial=0. Then DATA.
- DATA: transmit DATA_W bits, LSB first. Then PARITY if PARITY!=0, else STOP.
- PARITY: transmit the XOR of the data bits (even), or its inverse (odd).
- STOP: tx_serial=1 for STOP_BITS*CLK_DIV cycles.
  - On the final STOP cycle, if empty=0: pop and enter START directly, with no idle cycle and busy held at 1.
  - Otherwise enter IDLE.
- Latency: a write sampled at edge E0 into an empty FIFO while IDLE gives a pop at E1. tx_serial=0 from E1.
- Frame length: (1+DATA_W+(PARITY!=0)+STOP_BITS)*CLK_DIV cycles.
- busy=1 in every state except IDLE.
- Writes during transmission never disturb the frame in flight.

Test Plan:
1. CLK_DIV=4, PARITY=0, STOP_BITS=1. Write 0x55 once -> tx_serial sequence 0,1,0,1,0,1,0,1,0,1, each level 4 cycles, first start-bit cycle 1 cycle after the write. busy=1 for exactly 40 cycles, then busy=0 and empty=1.
2. PARITY=1, write 0x07 -> parity bit 1. PARITY=2, write 0x07 -> parity bit 0. Frame length 44 cycles at CLK_DIV=4.
3. FIFO_DEPTH=16. Write 18 bytes on consecutive cycles from IDLE -> bytes 1..17 accepted (byte 1 popped at once), count=16, full=1. Byte 18 dropped, overflow=1. All 17 accepted bytes emerge in write order.
4. Queue 0xA5 and 0x3C back to back -> STOP of 0xA5 lasts exactly CLK_DIV cycles, start of 0x3C follows immediately, busy never drops between frames.
5. Assert asyncreset=0 mid DATA bit 3 with 5 entries queued -> tx_serial=1, count=0, empty=1, busy=0, overflow=0 without a clock edge. After release, a single write of 0x81 transmits a correct frame.
6. STOP_BITS=2, PARITY=2, CLK_DIV=4 -> 48-cycle frame. With overflow=1, a cycle where clr_overflow=1 coincides with a dropped write leaves overflow=1. A later clr_overflow alone gives overflow=0.
